// File: rtl/vault_pkg.sv
// Shared types and constants for the vault phase-3 button sequence stage.
package vault_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    LOCKOUT,
    DONE,
    FAIL
  } state_t;

  localparam int NUM_BTN = 4;
  localparam int DIG_W   = 2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phase3_sequence_fsm_if.sv
// Phase-3 stage bus: phase-2 status and buttons in, sequence status out.
interface phase3_sequence_fsm_if;
  import vault_pkg::*;

  logic               phase2_done;
  logic               phase2_fail;
  logic [NUM_BTN-1:0] btn_in;
  logic               phase3_done;
  logic               phase3_fail;
  logic               alarm;
  logic [1:0]         attempts_left;
  logic [2:0]         progress;

  modport master (
    output phase2_done, phase2_fail, btn_in,
    input  phase3_done, phase3_fail, alarm,
    input  attempts_left, progress
  );

  modport slave (
    input  phase2_done, phase2_fail, btn_in,
    output phase3_done, phase3_fail, alarm,
    output attempts_left, progress
  );

endinterface

// File: rtl/btn_press_detect.sv
// Rising-edge detector for the button bank; classifies each cycle's presses.
module btn_press_detect
  import vault_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] i_btn,
  output logic               o_press_valid,
  output logic [DIG_W-1:0]   o_press_idx,
  output logic               o_press_multi
);

  logic [NUM_BTN-1:0] r_prev;
  logic [NUM_BTN-1:0] w_press;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_prev <= '0;
    else       r_prev <= i_btn;
  end

  assign w_press       = i_btn & ~r_prev;
  assign o_press_valid = $onehot(w_press);
  assign o_press_multi = (|w_press) & ~o_press_valid;

  always_comb begin
    o_press_idx = '0;
    for (int i = 0; i < NUM_BTN; i++)
      if (w_press[i]) o_press_idx = DIG_W'(i);
  end

endmodule

// File: rtl/phase3_sequence_fsm.sv
// Timed button-code entry with retries, lockout and sticky fail/alarm.
module phase3_sequence_fsm
  import vault_pkg::*;
#(
  parameter int                     SEQ_LEN        = 4,
  parameter logic [2*SEQ_LEN-1:0]   CODE           = 8'b10_00_11_01,
  parameter int                     TIMEOUT_CYCLES = 1000,
  parameter int                     LOCKOUT_CYCLES = 50,
  parameter int                     MAX_ATTEMPTS   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  phase3_sequence_fsm_if.slave  bus
);

  localparam int TMAX = max2(TIMEOUT_CYCLES, LOCKOUT_CYCLES);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [15:0] CODE_X = 16'(CODE);

  state_t          r_state, w_state;
  logic [TW-1:0]   r_timer, w_timer;
  logic [2:0]      r_progress, w_progress;
  logic [1:0]      r_attempts, w_attempts;

  logic            w_valid, w_multi, w_mistake;
  logic [DIG_W-1:0] w_idx, w_digit;

  btn_press_detect u_det (
    .clk           (clk),
    .reset         (reset),
    .i_btn         (bus.btn_in),
    .o_press_valid (w_valid),
    .o_press_idx   (w_idx),
    .o_press_multi (w_multi)
  );

  assign w_digit = CODE_X[{r_progress, 1'b0} +: DIG_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_progress <= '0;
      r_attempts <= 2'(MAX_ATTEMPTS);
    end else begin
      r_state    <= w_state;
      r_timer    <= w_timer;
      r_progress <= w_progress;
      r_attempts <= w_attempts;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_timer    = r_timer;
    w_progress = r_progress;
    w_attempts = r_attempts;
    w_mistake  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.phase2_fail) begin
          w_state = FAIL;
          w_timer = '0;
        end else if (bus.phase2_done) begin
          w_state    = ENTRY;
          w_progress = '0;
          w_timer    = '0;
        end
      end
      ENTRY: begin
        if (w_valid || w_multi) begin
          if (w_valid && w_idx == w_digit) begin
            w_timer = '0;
            if (r_progress == 3'(SEQ_LEN - 1)) w_state = DONE;
            else w_progress = r_progress + 3'd1;
          end else begin
            w_mistake = 1'b1;
          end
        end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
          w_mistake = 1'b1;
        end else begin
          w_timer = r_timer + 1'b1;
        end
        // A mistake on the last attempt is final; otherwise back off
        if (w_mistake) begin
          w_timer = '0;
          if (r_attempts == 2'd1) begin
            w_attempts = 2'd0;
            w_state    = FAIL;
          end else begin
            w_attempts = r_attempts - 2'd1;
            w_progress = '0;
            w_state    = LOCKOUT;
          end
        end
      end
      LOCKOUT: begin
        if (r_timer == TW'(LOCKOUT_CYCLES - 1)) begin
          w_state = ENTRY;
          w_timer = '0;
        end else begin
          w_timer = r_timer + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.phase3_done   = (r_state == DONE);
  assign bus.phase3_fail   = (r_state == FAIL);
  assign bus.alarm         = (r_state == FAIL);
  assign bus.attempts_left = r_attempts;
  assign bus.progress      = r_progress;

endmodule

// File: tb/tb_phase3_sequence_fsm.sv
// Directed bench for phase3_sequence_fsm with short timeout/lockout.
module tb_phase3_sequence_fsm;

  logic clk = 1'b0;
  logic reset;
  int   n_tot = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  phase3_sequence_fsm_if vif ();

  phase3_sequence_fsm #(
    .SEQ_LEN        (4),
    .CODE           (8'b10_00_11_01),
    .TIMEOUT_CYCLES (16),
    .LOCKOUT_CYCLES (4),
    .MAX_ATTEMPTS   (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int b);
    vif.btn_in = 4'(1 << b);
    step();
    vif.btn_in = '0;
    step();
  endtask

  task automatic do_reset();
    vif.phase2_done = 1'b0;
    vif.phase2_fail = 1'b0;
    vif.btn_in      = '0;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step();
  endtask

  task automatic chk_all(input string tag, input int d, input int f,
                         input int al, input int at, input int pr);
    chk({tag, ".done"},  int'(vif.phase3_done),   d);
    chk({tag, ".fail"},  int'(vif.phase3_fail),   f);
    chk({tag, ".alarm"}, int'(vif.alarm),         al);
    chk({tag, ".att"},   int'(vif.attempts_left), at);
    chk({tag, ".prog"},  int'(vif.progress),      pr);
  endtask

  initial begin
    vif.phase2_done = 1'b0;
    vif.phase2_fail = 1'b0;
    vif.btn_in      = '0;
    reset = 1'b1;
    #1;
    chk_all("rst", 0, 0, 0, 3, 0);
    step(2);
    reset = 1'b0;
    step();
    chk_all("idle", 0, 0, 0, 3, 0);

    // 1: pass path
    vif.phase2_done = 1'b1;
    step();
    press(1);
    chk("p1.prog1", int'(vif.progress), 1);
    press(3);
    chk("p1.prog2", int'(vif.progress), 2);
    press(0);
    chk("p1.prog3", int'(vif.progress), 3);
    chk("p1.notdone", int'(vif.phase3_done), 0);
    vif.btn_in = 4'b0100;
    step();
    chk_all("p1.end", 1, 0, 0, 3, 3);
    vif.btn_in = '0;

    // 2: upstream fail wins over done
    do_reset();
    vif.phase2_done = 1'b1;
    vif.phase2_fail = 1'b1;
    step();
    chk_all("p2.fail", 0, 1, 1, 3, 0);
    press(1); press(3); press(0); press(2);
    chk_all("p2.sticky", 0, 1, 1, 3, 0);

    // 3: wrong digit, lockout ignores presses
    do_reset();
    vif.phase2_done = 1'b1;
    step();
    press(1);
    chk("p3.prog1", int'(vif.progress), 1);
    vif.btn_in = 4'b0100;
    step();
    chk_all("p3.mis", 0, 0, 0, 2, 0);
    vif.btn_in = '0;
    step();
    press(1);
    chk("p3.lock.ign", int'(vif.progress), 0);
    vif.btn_in = 4'b0010;
    step();
    vif.btn_in = '0;
    step();
    chk("p3.lock.last", int'(vif.progress), 0);
    press(1);
    chk("p3.re1", int'(vif.progress), 1);
    press(3); press(0); press(2);
    chk_all("p3.done", 1, 0, 0, 2, 3);

    // 4: timeouts exhaust attempts
    do_reset();
    vif.phase2_done = 1'b1;
    step();
    step(15);
    chk("p4.t1.pre", int'(vif.attempts_left), 3);
    step();
    chk("p4.t1", int'(vif.attempts_left), 2);
    step(19);
    chk("p4.t2.pre", int'(vif.attempts_left), 2);
    step();
    chk("p4.t2", int'(vif.attempts_left), 1);
    step(19);
    chk_all("p4.t3.pre", 0, 0, 0, 1, 0);
    step();
    chk_all("p4.t3", 0, 1, 1, 0, 0);

    // 5a: held button does not count
    do_reset();
    vif.btn_in = 4'b0010;
    step();
    vif.phase2_done = 1'b1;
    step(3);
    chk("p5.held", int'(vif.progress), 0);
    vif.btn_in = '0;
    step();
    press(1);
    chk("p5.rel", int'(vif.progress), 1);
    // 5b: two buttons in one cycle
    vif.btn_in = 4'b1010;
    step();
    chk("p5.multi.att", int'(vif.attempts_left), 2);
    chk("p5.multi.prog", int'(vif.progress), 0);
    vif.btn_in = '0;

    // 5c: correct press exactly on the last timer value
    do_reset();
    vif.phase2_done = 1'b1;
    step();
    step(15);
    vif.btn_in = 4'b0010;
    step();
    vif.btn_in = '0;
    chk("p5.t15.att", int'(vif.attempts_left), 3);
    chk("p5.t15.prog", int'(vif.progress), 1);

    // 6: reset mid-entry
    do_reset();
    vif.phase2_done = 1'b1;
    step();
    press(1); press(3);
    chk("p6.prog2", int'(vif.progress), 2);
    press(2);
    chk("p6.mis", int'(vif.attempts_left), 2);
    vif.phase2_done = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_all("p6.rst", 0, 0, 0, 3, 0);
    step();
    reset = 1'b0;
    step();
    press(1);
    chk("p6.idle", int'(vif.progress), 0);
    vif.phase2_done = 1'b1;
    step();
    press(1);
    chk("p6.again", int'(vif.progress), 1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
